// File: rtl/modaddsub_pipe.sv
`default_nettype none
// =============================================================================
// Module   : modaddsub_pipe
// Purpose  : Three-stage multi-lane modular add/subtract, C = (A +/- B) mod q,
//            with valid/ready handshake, global stall and tag passthrough.
// Options  : MODADDSUB_RANGE_CHK_EN adds per-lane out_err range flags.
// Revision : 1.0  initial release
// =============================================================================
module modaddsub_pipe #(
  parameter int NLANE = 4,
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47,
  parameter int TAGW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sub,
  input  logic [NLANE*LOGQ-1:0] A,
  input  logic [NLANE*LOGQ-1:0] B,
  input  logic [LOGQ-1:0]       q,
  input  logic [TAGW-1:0]       tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NLANE*LOGQ-1:0] C,
  output logic [TAGW-1:0]       out_tag
`ifdef MODADDSUB_RANGE_CHK_EN
  ,
  output logic [NLANE-1:0]      out_err
`endif
);

  localparam int W  = LOGQ - LOGQH;
  localparam int SW = LOGQ + 1;

  logic                  w_adv;
  logic [LOGQ-1:0]       w_q_eff;
  logic                  w_unused_q;

  logic                  r_s0_valid;
  logic                  r_s0_sub;
  logic [TAGW-1:0]       r_s0_tag;
  logic [LOGQ-1:0]       r_s0_q;
  logic [NLANE*LOGQ-1:0] r_s0_a;
  logic [NLANE*LOGQ-1:0] r_s0_b;

  logic                  r_s1_valid;
  logic                  r_s1_sub;
  logic [TAGW-1:0]       r_s1_tag;
  logic [NLANE*SW-1:0]   r_s1_r;
  logic [NLANE*SW-1:0]   r_s1_rc;

  logic [NLANE*SW-1:0]   w_r;
  logic [NLANE*SW-1:0]   w_rc;
  logic [NLANE*LOGQ-1:0] w_c;

  // One advance signal for every stage: bubbles are kept, nothing reorders.
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // Low field of q is forced to {0..0,q[0]}; the dropped bits are intentionally unused.
  assign w_q_eff    = {q[LOGQ-1:W], {(W-1){1'b0}}, q[0]};
  assign w_unused_q = ^q[W-1:1];

  genvar i;
  generate
    for (i = 0; i < NLANE; i++) begin : g_lane
      logic [SW-1:0] a_x, b_x, q_x, r, rc, r1, rc1;

      assign a_x = {1'b0, r_s0_a[i*LOGQ +: LOGQ]};
      assign b_x = {1'b0, r_s0_b[i*LOGQ +: LOGQ]};
      assign q_x = {1'b0, r_s0_q};
      assign r   = r_s0_sub ? (a_x - b_x) : (a_x + b_x);
      assign rc  = r_s0_sub ? (r + q_x)   : (r - q_x);
      assign w_r[i*SW +: SW]  = r;
      assign w_rc[i*SW +: SW] = rc;

      // sub: take corrected value when the raw difference went negative;
      // add: take corrected value unless subtracting q went negative.
      assign r1  = r_s1_r[i*SW +: SW];
      assign rc1 = r_s1_rc[i*SW +: SW];
      assign w_c[i*LOGQ +: LOGQ] = (r_s1_sub ? r1[LOGQ] : ~rc1[LOGQ]) ?
                                   rc1[LOGQ-1:0] : r1[LOGQ-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_sub   <= 1'b0;
      r_s0_tag   <= '0;
      r_s0_q     <= '0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_sub   <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_r     <= '0;
      r_s1_rc    <= '0;
      out_valid  <= 1'b0;
      C          <= '0;
      out_tag    <= '0;
    end else if (w_adv) begin
      r_s0_valid <= in_valid;
      r_s0_sub   <= sub;
      r_s0_tag   <= tag;
      r_s0_q     <= w_q_eff;
      r_s0_a     <= A;
      r_s0_b     <= B;
      r_s1_valid <= r_s0_valid;
      r_s1_sub   <= r_s0_sub;
      r_s1_tag   <= r_s0_tag;
      r_s1_r     <= w_r;
      r_s1_rc    <= w_rc;
      out_valid  <= r_s1_valid;
      C          <= w_c;
      out_tag    <= r_s1_tag;
    end
  end

`ifdef MODADDSUB_RANGE_CHK_EN
  logic [NLANE-1:0] w_err;
  logic [NLANE-1:0] r_s1_err;

  generate
    for (i = 0; i < NLANE; i++) begin : g_err
      assign w_err[i] = (r_s0_a[i*LOGQ +: LOGQ] >= r_s0_q) |
                        (r_s0_b[i*LOGQ +: LOGQ] >= r_s0_q);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_err <= '0;
      out_err  <= '0;
    end else if (w_adv) begin
      r_s1_err <= w_err;
      out_err  <= r_s1_err;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_modaddsub_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_modaddsub_pipe
// Purpose  : Self-checking bench for modaddsub_pipe (vector table, stall,
//            reset and randomized scoreboard against an arithmetic model).
// Revision : 1.0  initial release
// =============================================================================
module tb_modaddsub_pipe;
  localparam int NLANE = 4;
  localparam int LOGQ  = 64;
  localparam int LOGQH = 47;
  localparam int TAGW  = 8;
  localparam logic [63:0] QF = 64'hFFFF_FFFF_FFFE_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sub, out_valid, out_ready;
  logic [255:0] A, B, C;
  logic [63:0]  q;
  logic [7:0]   tag, out_tag;
`ifdef MODADDSUB_RANGE_CHK_EN
  logic [3:0]   out_err;
`endif

  always #5 clk = ~clk;

  modaddsub_pipe #(.NLANE(NLANE), .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .A(A), .B(B), .q(q), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .out_tag(out_tag)
`ifdef MODADDSUB_RANGE_CHK_EN
    , .out_err(out_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] qeff(input logic [63:0] qq);
    return {qq[63:17], 16'b0, qq[0]};
  endfunction

  // Reference: plain modular arithmetic on in-range operands.
  function automatic logic [255:0] model(input logic s, input logic [255:0] a,
                                         input logic [255:0] b, input logic [63:0] qq);
    logic [127:0] m, x, y;
    logic [255:0] res;
    m = {64'b0, qeff(qq)};
    for (int l = 0; l < 4; l++) begin
      x = {64'b0, a[l*64 +: 64]};
      y = {64'b0, b[l*64 +: 64]};
      res[l*64 +: 64] = s ? 64'((x + m - y) % m) : 64'((x + y) % m);
    end
    return res;
  endfunction

  function automatic logic [255:0] lanes(input logic [63:0] l0, input logic [63:0] l1,
                                         input logic [63:0] l2, input logic [63:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [255:0] rnd_ops(input logic [63:0] qe);
    logic [255:0] v;
    for (int l = 0; l < 4; l++) v[l*64 +: 64] = {$urandom, $urandom} % qe;
    return v;
  endfunction

  typedef struct {
    logic         s;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] c;
  } vec_t;

  typedef struct packed {
    logic [255:0] c;
    logic [7:0]   t;
  } exp_t;

  vec_t         tv[8];
  exp_t         sbq[$];
  exp_t         e;
  bit           sb_en = 1'b0;
  int           popped = 0;
  logic         last_acc = 1'b0;
  logic         prev_stall = 1'b0;
  logic [255:0] prev_c;
  logic [7:0]   prev_t;

  // Scoreboard monitor: inputs/outputs are stable at the falling edge.
  always @(negedge clk) begin
    last_acc = in_valid && in_ready && !rst;
    if (sb_en) begin
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_c", C, prev_c);
        check("stall_hold_tag", out_tag, prev_t);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %0h expected no output", out_tag);
        end else begin
          e = sbq.pop_front();
          check("sb_c", C, e.c);
          check("sb_tag", out_tag, e.t);
          popped++;
        end
      end
      if (in_valid && in_ready) sbq.push_back('{c: model(sub, A, B, q), t: tag});
    end
    prev_stall = out_valid && !out_ready;
    prev_c     = C;
    prev_t     = out_tag;
  end

  initial begin
    int n;
    int idx;
    logic [63:0] qe;

    rst = 1'b1; in_valid = 1'b0; sub = 1'b0; A = '0; B = '0; q = QF; tag = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_c", C, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    tv[0] = '{1'b1, lanes(5, 5, 5, 5), lanes(3, 3, 3, 3), lanes(2, 2, 2, 2)};
    tv[1] = '{1'b1, lanes(3, 3, 3, 3), lanes(5, 5, 5, 5),
              lanes(64'hFFFF_FFFF_FFFD_FFFF, 64'hFFFF_FFFF_FFFD_FFFF,
                    64'hFFFF_FFFF_FFFD_FFFF, 64'hFFFF_FFFF_FFFD_FFFF)};
    tv[2] = '{1'b1, lanes(0, QF-1, 7, 0), lanes(0, 0, 7, 1), lanes(0, QF-1, 0, QF-1)};
    tv[3] = '{1'b0, lanes(QF-1, QF-1, QF-1, QF-1), lanes(1, 1, 1, 1), lanes(0, 0, 0, 0)};
    tv[4] = '{1'b0, lanes(QF-1, QF-1, QF-1, QF-1), lanes(QF-1, QF-1, QF-1, QF-1),
              lanes(QF-2, QF-2, QF-2, QF-2)};
    tv[5] = '{1'b0, lanes(1, 1, 1, 1), lanes(2, 2, 2, 2), lanes(3, 3, 3, 3)};
    tv[6] = '{1'b0, lanes(0, 5, QF-1, 100), lanes(0, QF-5, 2, QF-100), lanes(0, 0, 1, 0)};
    tv[7] = '{1'b1, lanes(0, 1, QF-1, 10), lanes(QF-1, QF-1, 0, 10), lanes(1, 2, QF-1, 0)};

    // Single transactions: exact latency, value and tag.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; sub = tv[i].s; A = tv[i].a; B = tv[i].b; q = QF; tag = 8'(8'h11 + i);
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        in_valid = 1'b0;
      end while (!out_valid && n < 10);
      check($sformatf("tbl%0d_latency", i), n, 3);
      check($sformatf("tbl%0d_c", i), C, tv[i].c);
      check($sformatf("tbl%0d_tag", i), out_tag, 8'(8'h11 + i));
`ifdef MODADDSUB_RANGE_CHK_EN
      check($sformatf("tbl%0d_err", i), out_err, 0);
`endif
    end
    @(posedge clk); #1;

    // Ten back-to-back ops, alternating mode, consumer stalls cycles 4..8.
    sb_en = 1'b1; popped = 0; idx = 0; q = QF;
    for (int c = 0; c < 40; c++) begin
      if (last_acc) idx++;
      out_ready = !(c >= 4 && c <= 8);
      if (idx < 10) begin
        in_valid = 1'b1; tag = 8'(idx); sub = idx[0];
        A = rnd_ops(qeff(QF)); B = rnd_ops(qeff(QF));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("stream_popped", popped, 10);
    check("stream_queue_empty", sbq.size(), 0);

    // Randomized traffic: random modulus (junk in ignored bits), mode and handshakes.
    popped = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sub = 1'($urandom_range(0, 1));
      q = {1'b1, 31'($urandom), $urandom};
      qe = qeff(q);
      A = rnd_ops(qe); B = rnd_ops(qe); tag = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rand_drained", sbq.size(), 0);
    check("rand_some_outputs", popped > 50, 1);
    sb_en = 1'b0;

    // Asynchronous reset mid-cycle with two ops still in flight.
    q = QF; sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; A = lanes(1, 1, 1, 1); B = lanes(1, 1, 1, 1); tag = 8'(8'hA0 + k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_c", C, 0);
    check("async_rst_tag", out_tag, 0);
    check("async_rst_in_ready", in_ready, 1);
    #7 rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("post_rst_no_output", n, 0);

`ifdef MODADDSUB_RANGE_CHK_EN
    in_valid = 1'b1; sub = 1'b0; q = QF; tag = 8'h66;
    A = lanes(1, 1, QF, 1); B = lanes(1, 1, 1, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      in_valid = 1'b0;
    end while (!out_valid && n < 10);
    check("err_valid", out_valid, 1);
    check("err_flags", out_err, 4'b0100);
    check("err_c", C, lanes(2, 2, 1, 2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
